// File: rtl/systolic_array_ctrl.sv
// Sequencer for an N x N weight-stationary PE array: loads weights, streams
// skewed activation vectors, and deskews the bottom-row accumulators into results.
module systolic_array_ctrl #(
  parameter int WBITS = 8,
  parameter int ABITS = 16,
  parameter int N     = 4,
  parameter int VBITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [VBITS-1:0]       num_vecs,
  output logic                   busy,
  output logic                   done,
  output logic                   w_rd_en,
  output logic [$clog2(N)-1:0]   w_rd_addr,
  input  logic [N*WBITS-1:0]     w_rd_data,
  output logic                   a_rd_en,
  output logic [VBITS-1:0]       a_rd_addr,
  input  logic [N*WBITS-1:0]     a_rd_data,
  output logic                   array_load,
  output logic [N*WBITS-1:0]     array_w_in,
  output logic [N*WBITS-1:0]     array_pass,
  input  logic [N*ABITS-1:0]     array_acc,
  output logic                   res_valid,
  output logic [N*ABITS-1:0]     res_vec,
  output logic [2:0]             dbg_state_o
);

  localparam int AW = $clog2(N);
  localparam int KW = $clog2(N + 1);
  localparam int TD = 2 * N + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [VBITS-1:0] m_q, m_d;
  logic [VBITS-1:0] nv_q, nv_d;
  logic [TD-1:0]    tok_q;

  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      m_q     <= '0;
      nv_q    <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      nv_q    <= nv_d;
      tok_q   <= {tok_q[TD-2:0], a_rd_en};
    end
  end

  // Handshake: start is a pulse honoured only in IDLE; busy covers every cycle
  // from the one after the accepted start through the single done cycle.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    m_d        = m_q;
    nv_d       = nv_q;
    busy       = 1'b0;
    done       = 1'b0;
    w_rd_en    = 1'b0;
    w_rd_addr  = '0;
    a_rd_en    = 1'b0;
    a_rd_addr  = '0;
    array_load = 1'b0;
    array_w_in = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d    = num_vecs;
          k_d     = '0;
          m_d     = '0;
          state_d = S_WLOAD;
        end
      end
      S_WLOAD: begin
        busy = 1'b1;
        // Bottom row is read first so it ends up deepest in the weight chain.
        if (k_q < KW'(N)) begin
          w_rd_en   = 1'b1;
          w_rd_addr = AW'(N - 1 - int'(k_q));
        end
        if (k_q != '0) begin
          array_load = 1'b1;
          array_w_in = w_rd_data;
        end
        if (k_q == KW'(N)) state_d = (nv_q == '0) ? S_DONE : S_STREAM;
        else               k_d     = k_q + KW'(1);
      end
      S_STREAM: begin
        busy      = 1'b1;
        a_rd_en   = 1'b1;
        a_rd_addr = m_q;
        if (m_q == nv_q - VBITS'(1)) state_d = S_DRAIN;
        else                         m_d     = m_q + VBITS'(1);
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tok_q[TD-1] && (tok_q[TD-2:0] == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Row 0 takes the SRAM output directly; row r goes through r registers.
  assign array_pass[WBITS-1:0] = tok_q[0] ? a_rd_data[WBITS-1:0] : '0;

  for (genvar r = 1; r < N; r++) begin : g_skew
    logic [WBITS-1:0] sk_q [r];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j < r; j++) sk_q[j] <= '0;
      end else begin
        sk_q[0] <= tok_q[0] ? a_rd_data[r*WBITS +: WBITS] : '0;
        for (int j = 1; j < r; j++) sk_q[j] <= sk_q[j-1];
      end
    end
    assign array_pass[r*WBITS +: WBITS] = sk_q[r-1];
  end

  assign res_valid = tok_q[TD-1];

  // Column c arrives c cycles after column 0, so it needs N-c register stages.
  for (genvar c = 0; c < N; c++) begin : g_deskew
    logic [ABITS-1:0] dq_q [N-c];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j < N - c; j++) dq_q[j] <= '0;
      end else begin
        dq_q[0] <= array_acc[c*ABITS +: ABITS];
        for (int j = 1; j < N - c; j++) dq_q[j] <= dq_q[j-1];
      end
    end
    assign res_vec[c*ABITS +: ABITS] = tok_q[TD-1] ? dq_q[N-c-1] : '0;
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: SRAM models, a behavioural PE grid, and a
// scoreboard of expected result vectors and read addresses.
module tb_systolic_array_ctrl;

  localparam int N     = 4;
  localparam int WBITS = 8;
  localparam int ABITS = 16;
  localparam int VBITS = 8;

  logic                 clk, reset, start;
  logic [VBITS-1:0]     num_vecs;
  logic                 busy, done, w_rd_en, a_rd_en, array_load, res_valid;
  logic [$clog2(N)-1:0] w_rd_addr;
  logic [VBITS-1:0]     a_rd_addr;
  logic [N*WBITS-1:0]   w_rd_data, a_rd_data, array_w_in, array_pass;
  logic [N*ABITS-1:0]   array_acc, res_vec;
  logic [2:0]           dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [N*WBITS-1:0] wmem [N];
  logic [N*WBITS-1:0] amem [256];
  logic [WBITS-1:0]   pe_w [N][N];
  logic [WBITS-1:0]   pe_a [N][N];
  logic [ABITS-1:0]   pe_p [N][N];

  logic [N*ABITS-1:0] exp_q [$];
  int                 exp_t_q [$];
  logic [VBITS-1:0]   addr_q [$];

  systolic_array_ctrl #(.WBITS(WBITS), .ABITS(ABITS), .N(N), .VBITS(VBITS)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .array_load(array_load), .array_w_in(array_w_in), .array_pass(array_pass),
    .array_acc(array_acc), .res_valid(res_valid), .res_vec(res_vec),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAMs: data one cycle after the read enable
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
  end

  // Behavioural weight-stationary grid: activations move right, sums move down.
  function automatic logic [WBITS-1:0] pe_ain(input int r, input int c);
    return (c == 0) ? array_pass[r*WBITS +: WBITS] : pe_a[r][(c > 0) ? c - 1 : 0];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (reset) begin
          pe_w[r][c] <= '0;
          pe_a[r][c] <= '0;
          pe_p[r][c] <= '0;
        end else begin
          if (array_load)
            pe_w[r][c] <= (r == 0) ? array_w_in[c*WBITS +: WBITS] : pe_w[(r > 0) ? r - 1 : 0][c];
          pe_a[r][c] <= pe_ain(r, c);
          pe_p[r][c] <= ((r == 0) ? ABITS'(0) : pe_p[(r > 0) ? r - 1 : 0][c])
                        + ABITS'(pe_w[r][c]) * ABITS'(pe_ain(r, c));
        end
      end
    end
  end

  always_comb begin
    array_acc = '0;
    for (int c = 0; c < N; c++) array_acc[c*ABITS +: ABITS] = pe_p[N-1][c];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: column c = sum over rows r of W[r][c] * x[r], modulo 2^ABITS.
  function automatic logic [N*ABITS-1:0] model(input logic [N*WBITS-1:0] x);
    logic [N*ABITS-1:0] res;
    logic [ABITS-1:0]   acc;
    res = '0;
    for (int c = 0; c < N; c++) begin
      acc = '0;
      for (int r = 0; r < N; r++)
        acc = acc + ABITS'(wmem[r][c*WBITS +: WBITS]) * ABITS'(x[r*WBITS +: WBITS]);
      res[c*ABITS +: ABITS] = acc;
    end
    return res;
  endfunction

  // scoreboard: read addresses and result vectors
  always @(negedge clk) begin
    if (a_rd_en) begin
      if (addr_q.size() == 0) check("a_rd_unexpected", a_rd_en, 1'b0);
      else                    check("a_rd_addr", a_rd_addr, addr_q.pop_front());
    end
    if (res_valid) begin
      if (exp_q.size() == 0) check("res_unexpected", res_valid, 1'b0);
      else begin
        check("res_vec", res_vec, exp_q.pop_front());
        check("res_cycle", cyc, exp_t_q.pop_front());
      end
    end
  end

  task automatic rand_weights();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wmem[r][c*WBITS +: WBITS] = WBITS'($urandom_range(0, 255));
  endtask

  task automatic rand_acts(input int cnt);
    for (int m = 0; m < cnt; m++)
      for (int r = 0; r < N; r++) amem[m][r*WBITS +: WBITS] = WBITS'($urandom_range(0, 255));
  endtask

  // Drives one job and follows it to done; returns at the negedge of the done cycle.
  task automatic run_job(input int n, input bit poke_busy, input bit poke_done);
    int s, exp_done, w_cnt, l_cnt, r_cnt, wl_cnt;
    bit seen;
    @(negedge clk);
    start    = 1'b1;
    num_vecs = VBITS'(n);
    s        = cyc;
    for (int m = 0; m < n; m++) begin
      exp_q.push_back(model(amem[m]));
      exp_t_q.push_back(s + 3*N + 3 + m);
      addr_q.push_back(VBITS'(m));
    end
    exp_done = (n == 0) ? s + N + 2 : s + 3*N + 3 + n;
    w_cnt = 0; l_cnt = 0; r_cnt = 0; wl_cnt = 0; seen = 1'b0;
    for (int b = 0; b < 2000 && !seen; b++) begin
      @(negedge clk);
      start = poke_busy && (cyc == s + 3);
      if (start) num_vecs = 8'd7;
      if (cyc == s + 1) check("busy_after_start", busy, 1'b1);
      if (w_rd_en) begin
        check("w_rd_addr", w_rd_addr, N - 1 - w_cnt);
        w_cnt++;
      end
      if (array_load) begin
        check("array_w_in", array_w_in, wmem[N - 1 - l_cnt]);
        l_cnt++;
      end
      if (a_rd_en) r_cnt++;
      if (dbg_state == 3'd1) wl_cnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    check("done_cycle", cyc, exp_done);
    check("busy_at_done", busy, 1'b1);
    check("w_reads", w_cnt, N);
    check("loads", l_cnt, N);
    check("wload_cycles", wl_cnt, N + 1);
    check("a_reads", r_cnt, n);
    check("results_left", exp_q.size(), 0);
    if (poke_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done_busy", busy, 1'b0);
      check("idle_after_done_state", dbg_state, 3'd0);
    end
  endtask

  initial begin
    int rd, rv;
    reset = 1'b1; start = 1'b0; num_vecs = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_w_rd_en", w_rd_en, 1'b0);
    check("rst_a_rd_en", a_rd_en, 1'b0);
    check("rst_load", array_load, 1'b0);
    check("rst_pass", array_pass, '0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_vec", res_vec, '0);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b0;

    // identity weights: results echo the inputs
    for (int r = 0; r < N; r++) begin
      wmem[r] = '0;
      wmem[r][r*WBITS +: WBITS] = 8'd1;
    end
    amem[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    amem[1] = {8'd8, 8'd7, 8'd6, 8'd5};
    amem[2] = {8'd9, 8'd0, 8'd0, 8'd0};
    check("model_identity", model(amem[2]), {16'd9, 16'd0, 16'd0, 16'd0});
    run_job(3, 1'b0, 1'b0);

    // back-to-back, all weights 2, saturating activations, stray start while busy
    for (int r = 0; r < N; r++) wmem[r] = {N{8'd2}};
    rand_acts(4);
    amem[0] = {N{8'd255}};
    check("model_all2", model(amem[0]), {N{16'd2040}});
    run_job(4, 1'b1, 1'b0);

    // zero vectors, start held through done cycle
    rand_weights();
    run_job(0, 1'b0, 1'b1);

    // reset after two activation reads
    rand_weights();
    rand_acts(6);
    @(negedge clk);
    start = 1'b1; num_vecs = 8'd6;
    for (int m = 0; m < 6; m++) addr_q.push_back(VBITS'(m));
    @(negedge clk);
    start = 1'b0;
    rd = 0;
    for (int b = 0; b < 100 && rd < 2; b++) begin
      @(negedge clk);
      if (a_rd_en) rd++;
    end
    check("two_reads", rd, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_a_rd_en", a_rd_en, 1'b0);
    check("mid_rst_pass", array_pass, '0);
    check("mid_rst_state", dbg_state, 3'd0);
    check("mid_rst_res_valid", res_valid, 1'b0);
    addr_q.delete();
    rv = 0;
    for (int b = 0; b < 3*N + 6; b++) begin
      @(negedge clk);
      if (res_valid || done) rv++;
    end
    check("no_output_after_reset", rv, 0);

    // fresh job after the reset
    rand_weights();
    rand_acts(5);
    run_job(5, 1'b0, 1'b0);

    // maximum vector count: addresses run 0..254
    rand_weights();
    rand_acts(256);
    run_job(255, 1'b0, 1'b0);

    @(negedge clk);
    check("queues_empty", exp_q.size() + addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
